shift_cmd_issuer: RTL and testbench
===================================

// Module: shift_cmd_issuer
// PURPOSE
//  - Upstream feeder for barrel_shifter: buffers shift commands (data, shift, dir) behind a
//    valid/ready port and issues them on barrel_shifter's unhandshaked inputs.
//  - Captures each registered result at a fixed latency and returns result plus echoed command,
//    in order, on a valid/ready output.
//  - Credit scheme: a result is never dropped under output backpressure.
// PARAMETERS
//  DATA_W     4  operand/result width (matches barrel_shifter)
//  SHIFT_W    2  shift-amount width
//  DEPTH      4  command FIFO entries (power of 2, >=2)
//  SHIFT_LAT  1  barrel_shifter register stages between sh_* inputs and sh_result
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        command present
//  in_ready   out  1        command FIFO not full; accept = in_valid & in_ready at posedge
//  in_data    in   DATA_W   operand
//  in_shift   in   SHIFT_W  shift amount
//  in_dir     in   1        0 = left, 1 = right
//  sh_data    out  DATA_W   to barrel_shifter.data
//  sh_shift   out  SHIFT_W  to barrel_shifter.shift
//  sh_dir     out  1        to barrel_shifter.dir
//  sh_issue   out  1        high for the cycle a new command is on sh_* (observability only)
//  sh_result  in   DATA_W   from barrel_shifter.result
//  out_valid  out  1        result FIFO not empty
//  out_ready  in   1        consumer takes the head at posedge when out_valid is high
//  out_result out  DATA_W   shifted value
//  out_data   out  DATA_W   echoed operand
//  out_shift  out  SHIFT_W  echoed amount
//  out_dir    out  1        echoed direction
// BEHAVIOUR
//  - Reset (async assert, sync release) clears the command FIFO, result FIFO and in-flight
//    pipeline. While rst_n is low: sh_*=0, sh_issue=0, out_*=0, in_ready=1.
//    No accept while rst_n is low. In-flight commands are discarded, never emitted.
//  - Command FIFO: in_ready=!cmd_full, combinational from the occupancy count.
//    Push and pop in the same cycle: count unchanged.
//    Full: no accept even if an issue pops that cycle; in_ready rises the next cycle.
//  - Issue: at a posedge when cmd FIFO is non-empty and inflight+res_count < RDEPTH
//    (RDEPTH = SHIFT_LAT+2):
//      pop the head into the sh_* registers, sh_issue=1 for one cycle.
//    sh_* hold their last value when idle.
//  - Capture: a tag pipeline of SHIFT_LAT+1 stages tracks issues (valid bit + echoed command).
//    On the (SHIFT_LAT+1)-th posedge after the issuing edge, push {sh_result, cmd} into the
//    result FIFO.
//  - inflight = number of set tag valid bits. The credit check makes the result FIFO unable
//    to overflow, so capture never stalls.
//  - Output: out_* show the result FIFO head, fall-through from a registered array.
//    Pop on out_valid & out_ready. Capture and pop in the same cycle are both honoured.
//  - Latency (SHIFT_LAT=1, empty block, out_ready=1):
//      accept at edge 0 -> issue at edge 1 -> capture at edge 3 -> out_valid high after edge 3.
//  - Throughput: 1 command/cycle sustained when out_ready=1.
//  - Total buffering under a full stall: DEPTH + RDEPTH commands (7 at defaults).
//  - Ordering: strict FIFO, in -> out. Pointers wrap modulo depth; counts are
//    $clog2(depth)+1 bits wide.
// STRUCTURE
//  - shift_pkg: DATA_W/SHIFT_W defaults, DIR_LEFT=1'b0, DIR_RIGHT=1'b1,
//    shift_cmd_t {data, shift, dir}.
//  - Sub-module sync_fifo (WIDTH, DEPTH; count/full/empty), instantiated twice:
//      command FIFO (shift_cmd_t), result FIFO (result + shift_cmd_t).
//  - Tag pipeline, credit counter and sh_* registers live in this module.
// TESTING (bench instantiates barrel_shifter; golden model = logical shift, zero fill, 1 reg stage)
//  1 Reset: rst_n=0 -> out_valid=0, sh_issue=0, in_ready=1; in_valid pulses during reset are
//    never emitted.
//  2 Single: 1101/01/left accepted at edge 0 -> out_valid after edge 3, out_result=1010,
//    echo 1101/01/0.
//  3 Stream: 8 back-to-back commands (1101, all shifts, both dirs), out_ready=1 ->
//    8 in-order results on consecutive cycles; in_ready stays 1.
//  4 Backpressure: out_ready=0, offer 10 commands -> exactly 7 accepted, then in_ready=0;
//    out_ready=1 -> 7 correct in-order results, then the remaining 3.
//  5 Full boundary: cmd FIFO full, issue pops -> in_ready=0 that cycle, 1 the next;
//    no command lost or duplicated.
//  6 Reset mid-op: 3 in flight + 2 buffered, rst_n low for 1 cycle -> all outputs 0
//    immediately; no stale result after release; the next command completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift command issuer and its barrel_shifter.
package shift_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int SHIFT_W_DEF = 2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]  data;
    logic [SHIFT_W_DEF-1:0] shift;
    logic                   dir;
  } shift_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and fall-through head.
// Depth need not be a power of two: pointers wrap explicitly.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_issuer.sv
// Feeds buffered shift commands into an unhandshaked barrel_shifter and
// collects its results in order behind a valid/ready port. Issue is gated by
// a credit check so the result FIFO can never overflow.
module shift_cmd_issuer
  import shift_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int DEPTH     = 4,
  parameter int SHIFT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_dir,
  output logic [DATA_W-1:0]  sh_data,
  output logic [SHIFT_W-1:0] sh_shift,
  output logic               sh_dir,
  output logic               sh_issue,
  input  logic [DATA_W-1:0]  sh_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [DATA_W-1:0]  out_data,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_dir
);

  // Result FIFO must cover everything that can be in the tag pipe plus one
  // entry being drained.
  localparam int RDEPTH = SHIFT_LAT + 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int RCW    = $clog2(RDEPTH) + 1;
  localparam int CRW    = RCW + 1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHIFT_W-1:0] shift;
    logic               dir;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    cmd_t              cmd;
  } res_t;

  // Command FIFO
  cmd_t          cmd_wr, cmd_head;
  logic          cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CW-1:0] cmd_count;

  // Result FIFO
  res_t           res_wr, res_head;
  logic           res_push, res_pop, res_full, res_empty;
  logic [RCW-1:0] res_count;

  // Tag pipeline: stage i holds the command issued i+1 edges ago.
  logic [SHIFT_LAT:0] tag_vld;
  cmd_t               tag_cmd [SHIFT_LAT+1];

  logic [CRW-1:0] inflight, credit_used;
  logic           issue;

  // Occupancy bits the issuer does not consume directly.
  logic unused_fifo_bits;
  assign unused_fifo_bits = ^{cmd_count, res_full};

  assign in_ready = ~cmd_full;
  assign cmd_push = in_valid & in_ready;
  assign cmd_wr   = '{data: in_data, shift: in_shift, dir: in_dir};
  assign cmd_pop  = issue;

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_wr),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .count (cmd_count),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  // Credit check. A result leaving this edge frees its slot immediately,
  // which is what sustains one command per cycle with out_ready held high.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= SHIFT_LAT; i++) inflight = inflight + CRW'(tag_vld[i]);
    credit_used = inflight + CRW'(res_count) - CRW'(res_pop);
    issue       = ~cmd_empty & (credit_used < CRW'(RDEPTH));
  end

  // Drive the shifter inputs; they hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data  <= '0;
      sh_shift <= '0;
      sh_dir   <= 1'b0;
      sh_issue <= 1'b0;
    end else begin
      sh_issue <= issue;
      if (issue) begin
        sh_data  <= cmd_head.data;
        sh_shift <= cmd_head.shift;
        sh_dir   <= cmd_head.dir;
      end
    end
  end

  // Tag pipeline mirrors the shifter's latency plus the issue register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i <= SHIFT_LAT; i++) tag_cmd[i] <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_cmd[0] <= cmd_head;
      for (int i = 1; i <= SHIFT_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_cmd[i] <= tag_cmd[i-1];
      end
    end
  end

  assign res_push = tag_vld[SHIFT_LAT];
  assign res_wr   = '{result: sh_result, cmd: tag_cmd[SHIFT_LAT]};
  assign res_pop  = out_valid & out_ready;

  sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RDEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_push),
    .wdata (res_wr),
    .pop   (res_pop),
    .rdata (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  // Output head is forced to zero when empty so stale storage never shows.
  assign out_valid  = ~res_empty;
  assign out_result = out_valid ? res_head.result    : '0;
  assign out_data   = out_valid ? res_head.cmd.data  : '0;
  assign out_shift  = out_valid ? res_head.cmd.shift : '0;
  assign out_dir    = out_valid ? res_head.cmd.dir   : 1'b0;

endmodule

// File: tb/tb_shift_cmd_issuer.sv
// Directed bench for shift_cmd_issuer with a one-stage barrel shifter model.
module tb_shift_cmd_issuer;
  import shift_pkg::*;

  logic       clk, rst_n;
  logic       in_valid, in_ready, in_dir;
  logic [3:0] in_data;
  logic [1:0] in_shift;
  logic [3:0] sh_data, sh_result;
  logic [1:0] sh_shift;
  logic       sh_dir, sh_issue;
  logic       out_valid, out_ready, out_dir;
  logic [3:0] out_result, out_data;
  logic [1:0] out_shift;

  shift_cmd_issuer #(.DATA_W(4), .SHIFT_W(2), .DEPTH(4), .SHIFT_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_dir(in_dir),
    .sh_data(sh_data), .sh_shift(sh_shift), .sh_dir(sh_dir), .sh_issue(sh_issue),
    .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_data(out_data), .out_shift(out_shift), .out_dir(out_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Barrel shifter stand-in: logical shift, zero fill, one register stage.
  always_ff @(posedge clk)
    sh_result <= sh_dir ? (sh_data >> sh_shift) : (sh_data << sh_shift);

  typedef struct {
    logic [3:0] data;
    logic [1:0] shift;
    logic       dir;
    logic [3:0] exp_res;
  } vec_t;

  typedef struct {
    shift_cmd_t cmd;
    logic [3:0] res;
  } exp_t;

  vec_t       vt [8];
  exp_t       exp_q [$];
  logic [3:0] cur_exp;
  int         n_chk, n_fail, cyc, pop_cnt, first_pop, last_pop, idx;
  logic       acc;

  function automatic logic [3:0] golden(input logic [3:0] d, input logic [1:0] s, input logic dir);
    return dir ? (d >> s) : (d << s);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: log the accept/pop that the coming edge performs, then advance.
  task automatic step();
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e.cmd.data  = in_data;
      e.cmd.shift = in_shift;
      e.cmd.dir   = in_dir;
      e.res       = cur_exp;
      exp_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", out_result);
      end else begin
        e = exp_q.pop_front();
        check("out_word", {out_result, out_data, out_shift, out_dir},
              {e.res, e.cmd.data, e.cmd.shift, e.cmd.dir});
      end
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic [3:0] d, input logic [1:0] s, input logic dir, input logic [3:0] r);
    in_valid = 1'b1; in_data = d; in_shift = s; in_dir = dir; cur_exp = r;
  endtask

  task automatic bp_drive(input int i);
    logic [3:0] d;
    logic [1:0] s;
    logic       dir;
    d = 4'(i * 5 + 3); s = 2'(i); dir = i[1];
    drive(d, s, dir, golden(d, s, dir));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; pop_cnt = 0; first_pop = 0; last_pop = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0;
    out_ready = 1'b1; cur_exp = '0;

    vt[0] = '{4'b1101, 2'd0, DIR_LEFT,  4'b1101};
    vt[1] = '{4'b1101, 2'd1, DIR_LEFT,  4'b1010};
    vt[2] = '{4'b1101, 2'd2, DIR_LEFT,  4'b0100};
    vt[3] = '{4'b1101, 2'd3, DIR_LEFT,  4'b1000};
    vt[4] = '{4'b1101, 2'd0, DIR_RIGHT, 4'b1101};
    vt[5] = '{4'b1101, 2'd1, DIR_RIGHT, 4'b0110};
    vt[6] = '{4'b1101, 2'd2, DIR_RIGHT, 4'b0011};
    vt[7] = '{4'b1101, 2'd3, DIR_RIGHT, 4'b0001};

    // 1: reset values; commands offered during reset never appear
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sh_issue", sh_issue, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_sh_data", sh_data, 0);
    drive(4'b1111, 2'd1, DIR_LEFT, 4'b1110);
    repeat (3) step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) step();
    check("rst_no_emit", pop_cnt, 0);
    check("rst_out_valid_after", out_valid, 0);

    // 2: single command latency
    pop_cnt = 0;
    drive(4'b1101, 2'd1, DIR_LEFT, 4'b1010);
    check("single_in_ready", in_ready, 1);
    step();                                   // edge 0: accept
    in_valid = 1'b0;
    check("single_e0_valid", out_valid, 0);
    check("single_e0_issue", sh_issue, 0);
    step();                                   // edge 1: issue
    check("single_e1_issue", sh_issue, 1);
    check("single_e1_sh", {sh_data, sh_shift, sh_dir}, {4'b1101, 2'd1, 1'b0});
    check("single_e1_valid", out_valid, 0);
    step();                                   // edge 2: shifter register
    check("single_e2_valid", out_valid, 0);
    check("single_e2_issue", sh_issue, 0);
    step();                                   // edge 3: capture
    check("single_e3_valid", out_valid, 1);
    check("single_result", out_result, 4'b1010);
    check("single_echo", {out_data, out_shift, out_dir}, {4'b1101, 2'd1, 1'b0});
    drain("single");
    check("single_pops", pop_cnt, 1);

    // 3: table-driven back-to-back stream
    pop_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].data, vt[i].shift, vt[i].dir, vt[i].exp_res);
      check("stream_in_ready", in_ready, 1);
      step();
    end
    drain("stream");
    check("stream_pops", pop_cnt, 8);
    check("stream_consecutive", last_pop - first_pop, 7);

    // 4/5: backpressure, then the full-FIFO boundary as the stall releases
    pop_cnt = 0; idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bp_drive(idx);
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 7);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_no_pop", pop_cnt, 0);
    out_ready = 1'b1;
    bp_drive(idx);
    check("full_edge_in_ready", in_ready, 0);
    step();
    check("full_next_in_ready", in_ready, 1);
    for (int c = 0; c < 20 && idx < 10; c++) begin
      bp_drive(idx);
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 10);
    drain("bp");
    check("bp_pops", pop_cnt, 10);

    // 6: reset with work in flight and buffered
    pop_cnt = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_drive(i);
      check("mid_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_word", {out_result, out_data, out_shift, out_dir}, 0);
    check("mid_rst_sh", {sh_data, sh_shift, sh_dir, sh_issue}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    check("mid_no_stale", pop_cnt, 0);
    drive(4'b0110, 2'd2, DIR_RIGHT, 4'b0001);
    step();
    drain("mid_after");
    check("mid_after_pops", pop_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
